// File: rtl/noc_output_arbiter_pkg.sv
// Shared definitions for the B-tree NoC output arbiter: default flit geometry,
// FSM state encoding and a small index helper.
package noc_output_arbiter_pkg;

    localparam int DEF_DATA_WIDTH = 36;
    localparam int DEF_ADDR_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Next index in a ring of n entries.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx == n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/noc_output_arbiter_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr,
// wrapping modulo N.
module noc_output_arbiter_rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    int j;

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        any = 1'b0;
        idx = '0;
        j   = 0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % N;
            if (req[j]) begin
                any = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/noc_output_arbiter.sv
// Round-robin arbiter for one switch output: selects among input-buffer heads
// whose destination falls in [DestMin,DestMax], with grant hold and burst limit.
module noc_output_arbiter
    import noc_output_arbiter_pkg::*;
#(
    parameter int DataWidth = DEF_DATA_WIDTH,
    parameter int AddrWidth = DEF_ADDR_WIDTH,
    parameter int NumIn     = 3,
    parameter int DestMin   = 0,
    parameter int DestMax   = 0,
    parameter int MaxBurst  = 4
) (
    input  logic                       i_sclk,
    input  logic                       i_reset,
    input  logic [NumIn*DataWidth-1:0] i_req_data,
    input  logic [NumIn-1:0]           i_req_valid,
    output logic [NumIn-1:0]           o_req_ready,
    output logic [DataWidth-1:0]       o_data,
    output logic                       o_data_valid,
    input  logic                       i_data_ready,
    output logic [NumIn-1:0]           o_grant,
    output logic [15:0]                o_xfer_count
);

    localparam int IW = $clog2(NumIn);
    localparam int BW = $clog2(MaxBurst + 1);

    // Handshake: a beat moves when o_data_valid & i_data_ready; o_req_ready is
    // that same event steered to the granted source, so it is the source's pop.

    arb_state_e       state;
    logic [IW-1:0]    gnt_idx;
    logic [IW-1:0]    rr_ptr;
    logic [BW-1:0]    burst_cnt;
    logic [15:0]      xfer_cnt;

    logic [NumIn-1:0] match;
    logic [IW-1:0]    gnt_next;
    logic [IW-1:0]    pick_ptr;
    logic             pick_any;
    logic [IW-1:0]    pick_idx;
    logic             cur_match;
    logic             xfer;
    logic             release_gnt;

    for (genvar g = 0; g < NumIn; g++) begin : g_match
        logic [AddrWidth-1:0] addr;
        assign addr     = i_req_data[g*DataWidth + DataWidth - 1 -: AddrWidth];
        assign match[g] = i_req_valid[g] && (int'(addr) >= DestMin) && (int'(addr) <= DestMax);
    end

    assign gnt_next = IW'(wrap_inc(int'(gnt_idx), NumIn));
    // In GRANT the picker is only consulted on release, starting after the holder.
    assign pick_ptr = (state == GRANT) ? gnt_next : rr_ptr;

    noc_output_arbiter_rr_pick #(.N(NumIn), .IW(IW)) u_pick (
        .req (match),
        .ptr (pick_ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign cur_match    = match[gnt_idx];
    // Outputs are masked during reset so no source beat is popped and lost.
    assign o_data_valid = (state == GRANT) && !i_reset && cur_match;
    assign xfer         = o_data_valid && i_data_ready;
    assign release_gnt  = (xfer && (burst_cnt == BW'(MaxBurst - 1))) || !cur_match;
    assign o_data       = i_req_data[int'(gnt_idx)*DataWidth +: DataWidth];
    assign o_xfer_count = xfer_cnt;

    always_comb begin
        o_req_ready = '0;
        o_grant     = '0;
        if (xfer) o_req_ready[gnt_idx] = 1'b1;
        if (state == GRANT) o_grant[gnt_idx] = 1'b1;
    end

    always_ff @(posedge i_sclk) begin
        if (i_reset) begin
            state     <= IDLE;
            gnt_idx   <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            xfer_cnt  <= '0;
        end else begin
            if (xfer) xfer_cnt <= xfer_cnt + 16'd1;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_idx   <= pick_idx;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) burst_cnt <= burst_cnt + BW'(1);
                    if (release_gnt) begin
                        rr_ptr <= gnt_next;
                        if (pick_any) begin
                            gnt_idx   <= pick_idx;
                            burst_cnt <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_output_arbiter.sv
// Directed bench for noc_output_arbiter with DestMin=2, DestMax=3, NumIn=3,
// MaxBurst=4; addresses 2/3 are routed here, 0/1 are not.
module tb_noc_output_arbiter;

    localparam int DW = 36;
    localparam int NI = 3;

    logic             i_sclk;
    logic             i_reset;
    logic [NI*DW-1:0] i_req_data;
    logic [NI-1:0]    i_req_valid;
    logic [NI-1:0]    o_req_ready;
    logic [DW-1:0]    o_data;
    logic             o_data_valid;
    logic             i_data_ready;
    logic [NI-1:0]    o_grant;
    logic [15:0]      o_xfer_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    noc_output_arbiter #(
        .DataWidth(DW), .AddrWidth(4), .NumIn(NI),
        .DestMin(2), .DestMax(3), .MaxBurst(4)
    ) dut (
        .i_sclk       (i_sclk),
        .i_reset      (i_reset),
        .i_req_data   (i_req_data),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_grant      (o_grant),
        .o_xfer_count (o_xfer_count)
    );

    // clock / reset
    initial i_sclk = 1'b0;
    always #5 i_sclk = ~i_sclk;

    task automatic tick();
        @(posedge i_sclk);
        #1;
    endtask

    task automatic do_reset();
        i_reset      = 1'b1;
        i_req_valid  = '0;
        i_req_data   = '0;
        i_data_ready = 1'b1;
        tick();
        i_reset = 1'b0;
    endtask

    // drivers
    task automatic set_in(input int i, input logic [3:0] addr, input logic [31:0] pay);
        i_req_data[i*DW +: DW] = {addr, pay};
    endtask

    function automatic logic [DW-1:0] mk(input logic [3:0] addr, input logic [31:0] pay);
        return {addr, pay};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        i_reset      = 1'b0;
        i_req_valid  = '0;
        i_req_data   = '0;
        i_data_ready = 1'b0;

        // reset state
        do_reset();
        #1;
        chk("rst_grant", 64'(o_grant), 64'd0);
        chk("rst_ready", 64'(o_req_ready), 64'd0);
        chk("rst_valid", 64'(o_data_valid), 64'd0);
        chk("rst_count", 64'(o_xfer_count), 64'd0);

        // reset mid-burst
        set_in(0, 4'd2, 32'd7);
        i_req_valid = 3'b001;
        tick();
        #1;
        chk("t1_grant", 64'(o_grant), 64'b001);
        chk("t1_ready", 64'(o_req_ready), 64'b001);
        tick();
        chk("t1_count1", 64'(o_xfer_count), 64'd1);
        i_reset = 1'b1;
        #1;
        chk("t1_rst_nopop", 64'(o_req_ready), 64'd0);
        chk("t1_rst_novalid", 64'(o_data_valid), 64'd0);
        tick();
        i_reset = 1'b0;
        #1;
        chk("t1_after_grant", 64'(o_grant), 64'd0);
        chk("t1_after_valid", 64'(o_data_valid), 64'd0);
        chk("t1_after_count", 64'(o_xfer_count), 64'd0);

        // single requester streams 10 flits
        do_reset();
        set_in(1, 4'd3, 32'd100);
        i_req_valid = 3'b010;
        #1;
        chk("t2_idle_valid", 64'(o_data_valid), 64'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            set_in(1, 4'd3, 32'(100 + k));
            #1;
            chk($sformatf("t2_valid%0d", k), 64'(o_data_valid), 64'd1);
            chk($sformatf("t2_grant%0d", k), 64'(o_grant), 64'b010);
            chk($sformatf("t2_data%0d", k), 64'(o_data), 64'(mk(4'd3, 32'(100 + k))));
            chk($sformatf("t2_ready%0d", k), 64'(o_req_ready), 64'b010);
            tick();
        end
        i_req_valid = 3'b000;
        #1;
        chk("t2_count", 64'(o_xfer_count), 64'd10);
        chk("t2_drained", 64'(o_data_valid), 64'd0);
        tick();
        chk("t2_idle_grant", 64'(o_grant), 64'd0);

        // three requesters, bursts of 4 in round-robin order
        do_reset();
        set_in(0, 4'd2, 32'hA0);
        set_in(1, 4'd2, 32'hA1);
        set_in(2, 4'd2, 32'hA2);
        i_req_valid = 3'b111;
        tick();
        for (int k = 0; k < 14; k++) begin
            #1;
            chk($sformatf("t3_grant%0d", k), 64'(o_grant), 64'(3'b001 << ((k / 4) % 3)));
            chk($sformatf("t3_ready%0d", k), 64'(o_req_ready), 64'(3'b001 << ((k / 4) % 3)));
            chk($sformatf("t3_data%0d", k), 64'(o_data), 64'(mk(4'd2, 32'(32'hA0 + (k / 4) % 3))));
            tick();
        end
        chk("t3_count", 64'(o_xfer_count), 64'd14);

        // stall with a competing request
        do_reset();
        set_in(1, 4'd3, 32'd11);
        set_in(2, 4'd2, 32'd22);
        i_req_valid = 3'b010;
        tick();
        i_req_valid  = 3'b110;
        i_data_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("t4_stall_grant%0d", k), 64'(o_grant), 64'b010);
            chk($sformatf("t4_stall_data%0d", k), 64'(o_data), 64'(mk(4'd3, 32'd11)));
            chk($sformatf("t4_stall_ready%0d", k), 64'(o_req_ready), 64'd0);
            chk($sformatf("t4_stall_valid%0d", k), 64'(o_data_valid), 64'd1);
            tick();
        end
        i_data_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("t4_go_grant%0d", k), 64'(o_grant), 64'b010);
            tick();
        end
        chk("t4_rotated", 64'(o_grant), 64'b100);
        chk("t4_data2", 64'(o_data), 64'(mk(4'd2, 32'd22)));
        chk("t4_count", 64'(o_xfer_count), 64'd4);

        // address filtering
        do_reset();
        set_in(0, 4'd1, 32'd1);
        set_in(1, 4'd3, 32'd2);
        i_req_valid = 3'b011;
        #1;
        chk("t5_idle_ready", 64'(o_req_ready), 64'd0);
        tick();
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("t5_grant%0d", k), 64'(o_grant), 64'b010);
            chk($sformatf("t5_ready%0d", k), 64'(o_req_ready), 64'b010);
            tick();
        end
        i_req_valid = 3'b001;
        #1;
        chk("t5_only0_ready", 64'(o_req_ready), 64'd0);
        chk("t5_only0_valid", 64'(o_data_valid), 64'd0);
        tick();
        chk("t5_only0_grant", 64'(o_grant), 64'd0);
        tick();
        chk("t5_only0_grant2", 64'(o_grant), 64'd0);
        chk("t5_only0_ready2", 64'(o_req_ready), 64'd0);

        // granted head re-routed out of range after two beats
        do_reset();
        set_in(0, 4'd2, 32'h50);
        set_in(2, 4'd2, 32'h52);
        i_req_valid = 3'b101;
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            chk($sformatf("t6_grant%0d", k), 64'(o_grant), 64'b001);
            tick();
        end
        set_in(0, 4'd1, 32'h50);
        #1;
        chk("t6_drop_valid", 64'(o_data_valid), 64'd0);
        chk("t6_drop_ready", 64'(o_req_ready), 64'd0);
        chk("t6_count", 64'(o_xfer_count), 64'd2);
        tick();
        chk("t6_next_grant", 64'(o_grant), 64'b100);
        chk("t6_next_valid", 64'(o_data_valid), 64'd1);
        chk("t6_next_data", 64'(o_data), 64'(mk(4'd2, 32'h52)));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
